// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the Beta pipeline sequencer.
// Contents: opcode constants, the compressed bubble IR, the per-stage record
// stage_t and helpers that classify opcodes and build stage records.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;

    // {rc,ra,rb} = {31,31,31}: reads and writes only R31, so it never hazards.
    localparam logic [14:0] NOP_IR = 15'h7FFF;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [14:0] ir;      // {rc,ra,rb}
        logic        ld;      // LD or LDR
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, opcode: 6'd0, ir: NOP_IR, ld: 1'b0};

    // Opcodes that write Rc: the listed memory/control ops and every op[5]=1 ALU op.
    function automatic logic writes_rc(input logic [5:0] op);
        return op[5] || (op == OP_LD) || (op == OP_LDR) || (op == OP_JMP) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Fetched 32-bit instruction -> valid stage record with raw register fields.
    function automatic stage_t compress(input logic [31:0] inst);
        stage_t s;
        s.valid  = 1'b1;
        s.opcode = inst[31:26];
        s.ir     = inst[25:11];
        s.ld     = (inst[31:26] == OP_LD) || (inst[31:26] == OP_LDR);
        return s;
    endfunction

    // Non-writers and Rc=R31 writers are given rc=31 and no LD flag so that
    // later stages never bypass from, stall on, or write R31.
    function automatic stage_t canonicalise(input stage_t s);
        stage_t c;
        c = s;
        if (!writes_rc(s.opcode) || (s.ir[14:10] == 5'd31)) begin
            c.ir[14:10] = 5'd31;
            c.ld        = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of fetch, branch, reg_file and counter signals around pipe_ctrl.
// master: environment side (fetch unit / reg_file / exec branch logic).
// slave : pipe_ctrl itself.
// Handshake: fetch_en is combinational from stall/annul in the same cycle;
// inst_f is consumed on a rising edge only when fetch_en && inst_valid_f.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst_f;
    logic             inst_valid_f;
    logic             annul;
    logic             stall;
    logic             fetch_en;
    logic [14:0]      ir_decode;
    logic [14:0]      ir_exec;
    logic [14:0]      ir_mem;
    logic [14:0]      ir_wb;
    logic [5:0]       op_exec;
    logic [5:0]       op_mem;
    logic             opcode_type_op;
    logic             op_ld_or_ldr_exec;
    logic             op_ld_or_ldr_mem;
    logic             op_ld_or_ldr_wb;
    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output inst_f, inst_valid_f, annul, stall,
        input  fetch_en, ir_decode, ir_exec, ir_mem, ir_wb, op_exec, op_mem,
               opcode_type_op, op_ld_or_ldr_exec, op_ld_or_ldr_mem, op_ld_or_ldr_wb,
               rf_we, rf_wa, stall_count, retire_count
    );

    modport slave (
        input  inst_f, inst_valid_f, annul, stall,
        output fetch_en, ir_decode, ir_exec, ir_mem, ir_wb, op_exec, op_mem,
               opcode_type_op, op_ld_or_ldr_exec, op_ld_or_ldr_mem, op_ld_or_ldr_wb,
               rf_we, rf_wa, stall_count, retire_count
    );
endinterface

// File: rtl/pipe_ctrl_stage_reg.sv
// One pipeline stage register (stage_t) with asynchronous reset to a bubble.
// Ports: clk_i, rst_i, bubble_i (highest priority, load a bubble),
//        load_i (load d_i), d_i, q_o. Neither control asserted -> hold.
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   bubble_i,
    input  logic   load_i,
    input  stage_t d_i,
    output stage_t q_o
);
    stage_t stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (bubble_i) begin
            stage_d = BUBBLE;
        end else if (load_i) begin
            stage_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 4-stage Beta core (decode/exec/mem/wb).
// Ports: clk, rst (async, active-high), bus (pipe_ctrl_if.slave) carrying
// fetch inputs, annul, reg_file stall, per-stage IR/opcode/LD outputs,
// reg_file write port and the saturating stall/retire counters.
// Edge priority: annul > stall > normal advance. mem and wb always advance.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    stage_t dec_s, exec_s, mem_s, wb_s;
    logic   dec_bubble, dec_load, exec_bubble;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Decode: annul kills wrong-path work even while stalled; a stall holds;
    // otherwise take the fetched instruction or a bubble if fetch had none.
    assign dec_bubble  = bus.annul || (!bus.stall && !bus.inst_valid_f);
    assign dec_load    = !bus.annul && !bus.stall && bus.inst_valid_f;
    // Exec receives a bubble on annul or stall; otherwise the canonicalised decode.
    assign exec_bubble = bus.annul || bus.stall;

    pipe_stage_reg u_dec (
        .clk_i(clk), .rst_i(rst), .bubble_i(dec_bubble), .load_i(dec_load),
        .d_i(compress(bus.inst_f)), .q_o(dec_s)
    );

    pipe_stage_reg u_exec (
        .clk_i(clk), .rst_i(rst), .bubble_i(exec_bubble), .load_i(1'b1),
        .d_i(canonicalise(dec_s)), .q_o(exec_s)
    );

    pipe_stage_reg u_mem (
        .clk_i(clk), .rst_i(rst), .bubble_i(1'b0), .load_i(1'b1),
        .d_i(exec_s), .q_o(mem_s)
    );

    pipe_stage_reg u_wb (
        .clk_i(clk), .rst_i(rst), .bubble_i(1'b0), .load_i(1'b1),
        .d_i(mem_s), .q_o(wb_s)
    );

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (bus.stall && !bus.annul && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (wb_s.valid && (retire_cnt_q != {CNT_W{1'b1}})) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.fetch_en          = !bus.stall || bus.annul;
    assign bus.ir_decode         = dec_s.ir;
    assign bus.ir_exec           = exec_s.ir;
    assign bus.ir_mem            = mem_s.ir;
    assign bus.ir_wb             = wb_s.ir;
    assign bus.op_exec           = exec_s.opcode;
    assign bus.op_mem            = mem_s.opcode;
    assign bus.opcode_type_op    = (dec_s.opcode[5:4] == 2'b10);
    assign bus.op_ld_or_ldr_exec = exec_s.ld;
    assign bus.op_ld_or_ldr_mem  = mem_s.ld;
    assign bus.op_ld_or_ldr_wb   = wb_s.ld;
    assign bus.rf_we             = wb_s.valid && writes_rc(wb_s.opcode) &&
                                   (wb_s.ir[14:10] != 5'd31);
    assign bus.rf_wa             = wb_s.ir[14:10];
    assign bus.stall_count       = stall_cnt_q;
    assign bus.retire_count      = retire_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Instruction-level reference: each slot holds one instruction or a bubble.
  typedef struct {
    bit v;
    int op;
    int rc;
    int ra;
    int rb;
  } minst_t;

  minst_t m_dec, m_ex, m_mem, m_wb;
  int m_stall_cnt, m_ret_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic minst_t bubble();
    minst_t b;
    b.v = 0; b.op = 0; b.rc = 31; b.ra = 31; b.rb = 31;
    return b;
  endfunction

  function automatic bit m_writer(int op);
    return (op >= 32) || (op == 24) || (op == 31) || (op == 27) || (op == 28) || (op == 29);
  endfunction

  function automatic bit m_is_ld(int op);
    return (op == 24) || (op == 31);
  endfunction

  function automatic logic [14:0] m_ir(minst_t s);
    logic [4:0] rc, ra, rb;
    rc = 5'(s.rc); ra = 5'(s.ra); rb = 5'(s.rb);
    return {rc, ra, rb};
  endfunction

  function automatic logic [31:0] mk(int op, int rc, int ra, int rb);
    logic [5:0] o;
    logic [4:0] c, a, b;
    o = 6'(op); c = 5'(rc); a = 5'(ra); b = 5'(rb);
    return {o, c, a, b, 11'h0};
  endfunction

  // Instructions entering exec that cannot usefully write a register target R31.
  function automatic minst_t to_exec(minst_t s);
    minst_t c;
    c = s;
    if (!m_writer(s.op)) c.rc = 31;
    return c;
  endfunction

  function automatic bit m_ld_flag(minst_t s);
    return m_is_ld(s.op) && s.rc != 31;
  endfunction

  task automatic model_reset();
    m_dec = bubble(); m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    m_stall_cnt = 0; m_ret_cnt = 0;
  endtask

  task automatic model_edge(input logic [31:0] inst, input bit iv, input bit an, input bit st);
    minst_t f;
    if (m_wb.v && m_ret_cnt < CMAX) m_ret_cnt++;
    if (st && !an && m_stall_cnt < CMAX) m_stall_cnt++;
    m_wb  = m_mem;
    m_mem = m_ex;
    if (an) begin
      m_ex = bubble(); m_dec = bubble();
    end else if (st) begin
      m_ex = bubble();
    end else begin
      m_ex = to_exec(m_dec);
      if (iv) begin
        f.v = 1; f.op = int'(inst[31:26]); f.rc = int'(inst[25:21]);
        f.ra = int'(inst[20:16]); f.rb = int'(inst[15:11]);
        m_dec = f;
      end else begin
        m_dec = bubble();
      end
    end
  endtask

  task automatic check_outputs();
    logic [5:0] dop;
    dop = 6'(m_dec.op);
    check("ir_decode", bus.ir_decode, m_ir(m_dec));
    check("ir_exec", bus.ir_exec, m_ir(m_ex));
    check("ir_mem", bus.ir_mem, m_ir(m_mem));
    check("ir_wb", bus.ir_wb, m_ir(m_wb));
    check("op_exec", bus.op_exec, 64'(m_ex.op));
    check("op_mem", bus.op_mem, 64'(m_mem.op));
    check("type_op", bus.opcode_type_op, (dop[5:4] == 2'b10));
    check("ld_exec", bus.op_ld_or_ldr_exec, m_ld_flag(m_ex));
    check("ld_mem", bus.op_ld_or_ldr_mem, m_ld_flag(m_mem));
    check("ld_wb", bus.op_ld_or_ldr_wb, m_ld_flag(m_wb));
    check("rf_we", bus.rf_we, m_wb.v && m_writer(m_wb.op) && m_wb.rc != 31);
    check("rf_wa", bus.rf_wa, 64'(m_wb.rc));
    check("stall_cnt", bus.stall_count, 64'(m_stall_cnt));
    check("retire_cnt", bus.retire_count, 64'(m_ret_cnt));
  endtask

  // Called just after a falling edge: drive, check fetch_en, clock, check state.
  task automatic step(input logic [31:0] inst, input bit iv, input bit an, input bit st);
    bus.inst_f = inst; bus.inst_valid_f = iv; bus.annul = an; bus.stall = st;
    #1;
    check("fetch_en", bus.fetch_en, !st || an);
    @(posedge clk);
    model_edge(inst, iv, an, st);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 7))
      0: return 24;
      1: return 31;
      2: return 25;
      3: return $urandom_range(27, 29);
      4: return $urandom_range(0, 23);
      default: return $urandom_range(32, 63);
    endcase
  endfunction

  int s0;

  initial begin
    bus.inst_f = '0; bus.inst_valid_f = 0; bus.annul = 0; bus.stall = 0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // ADD R1,R2,R3 then NOPs: reaches wb after 4 edges.
    step(mk(32, 1, 2, 3), 1, 0, 0);
    idle(3);
    check("t1_ir_wb", bus.ir_wb, {5'd1, 5'd2, 5'd3});
    check("t1_we", bus.rf_we, 1'b1);
    check("t1_wa", bus.rf_wa, 5'd1);
    idle(1);
    check("t1_ret", bus.retire_count, 8'd1);

    // LD R4 then ADD R5,R4,R6 with a 3-cycle load-use stall.
    s0 = int'(bus.stall_count);
    step(mk(24, 4, 1, 0), 1, 0, 0);
    step(mk(32, 5, 4, 6), 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(mk(33, 9, 9, 9), 1, 0, 1);
      check("t2_hold", bus.ir_decode, {5'd5, 5'd4, 5'd6});
      check("t2_bub", bus.ir_exec, 15'h7FFF);
    end
    check("t2_stalls", bus.stall_count, 8'(s0 + 3));
    idle(5);

    // BEQ in exec, SUB R7 in decode; annul during stall kills SUB.
    step(mk(28, 2, 3, 4), 1, 0, 0);
    step(mk(33, 7, 1, 2), 1, 0, 0);
    step(mk(32, 8, 8, 8), 1, 1, 1);
    check("t3_dec", bus.ir_decode, 15'h7FFF);
    check("t3_exec", bus.ir_exec, 15'h7FFF);
    check("t3_opmem", bus.op_mem, 6'h1C);
    idle(5);

    // ST R8 and LD R31 flow through without any write.
    step(mk(25, 8, 1, 2), 1, 0, 0);
    step(mk(24, 31, 3, 0), 1, 0, 0);
    check("t4_st_rc", bus.ir_exec[14:10], 5'd31);
    step(32'h0, 0, 0, 0);
    check("t4_ld_rc", bus.ir_exec[14:10], 5'd31);
    check("t4_ld_flag", bus.op_ld_or_ldr_exec, 1'b0);
    idle(4);

    // Asynchronous reset with three valid stages in flight.
    step(mk(32, 1, 1, 1), 1, 0, 0);
    step(mk(33, 2, 2, 2), 1, 0, 0);
    step(mk(34, 3, 3, 3), 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("t5_dec", bus.ir_decode, 15'h7FFF);
    check("t5_exec", bus.ir_exec, 15'h7FFF);
    check("t5_mem", bus.ir_mem, 15'h7FFF);
    check("t5_wb", bus.ir_wb, 15'h7FFF);
    check("t5_we", bus.rf_we, 1'b0);
    check("t5_ret", bus.retire_count, 8'd0);
    check("t5_stc", bus.stall_count, 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic long enough for both counters to saturate.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 3) == 0 ? 31 : $urandom_range(0, 30);
      step(mk(rand_op(), r, $urandom_range(0, 31), $urandom_range(0, 31)),
           $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    end
    if (m_ret_cnt == CMAX) begin
      step(mk(32, 1, 2, 3), 1, 0, 0);
      check("t6_sat", bus.retire_count, 8'hFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
